// File: rtl/pll_reset_ce_gen_if.sv
// pll_reset_ce_gen_if
//   Groups the lock/restart inputs and the reset/enable outputs of
//   pll_reset_ce_gen. clk and rst stay plain ports on the module.
//
//   pll_locked  PLL locked flag, asynchronous to clk
//   soft_rst    synchronous core-restart request, level-sampled
//   core_rst    registered active-high reset to core logic
//   ready       high while the core is released and running
//   ce_pix      one-cycle pixel clock enable
//   ce_aud      one-cycle audio clock enable
//   lock_lost   sticky loss-of-lock flag
//
//   master: the generator side (pll_reset_ce_gen)
//   slave : the side that drives lock/restart and consumes the outputs
interface pll_reset_ce_gen_if;
  logic pll_locked;
  logic soft_rst;
  logic core_rst;
  logic ready;
  logic ce_pix;
  logic ce_aud;
  logic lock_lost;

  modport master (
    input  pll_locked, soft_rst,
    output core_rst, ready, ce_pix, ce_aud, lock_lost
  );

  modport slave (
    output pll_locked, soft_rst,
    input  core_rst, ready, ce_pix, ce_aud, lock_lost
  );
endinterface

// File: rtl/pll_reset_ce_gen.sv
// pll_reset_ce_gen
//   Sits behind the core PLL on clk_sys (PLL outclk_0, 49.147727 MHz).
//   Synchronizes the PLL locked flag, holds the core in reset until lock
//   has been stable for HOLD_CYCLES, then generates single-cycle pixel and
//   audio clock enables so the whole core runs on one clock. A loss of
//   lock re-asserts core reset and sets a sticky flag.
//
//   Ports:
//     clk   system clock (PLL outclk_0)
//     rst   asynchronous, active-high reset
//     bus   pll_reset_ce_gen_if.master: pll_locked, soft_rst in;
//           core_rst, ready, ce_pix, ce_aud, lock_lost out (all registered)
//
//   Optional build macro LOCK_FILTER_EN: when defined, loss of lock needs
//   LOCK_FILTER consecutive low cycles of the synchronized flag; shorter
//   glitches are ignored. When undefined, any single low cycle in HOLD or
//   RUN is a loss and no filter counter is built.
//
//   state     | meaning
//   ----------+--------------------------------------------------------
//   WAIT_LOCK | core in reset, waiting for synchronized lock
//   HOLD      | core in reset, lock must stay good for HOLD_CYCLES
//   RUN       | core released, ready=1, clock enables running
//   LOST      | one-cycle stop after loss of lock, sets lock_lost
module pll_reset_ce_gen #(
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 1024,
  parameter int CE_DIV      = 8,
  parameter int AUD_DIV     = 1024,
  parameter int LOCK_FILTER = 8
) (
  input  logic               clk,
  input  logic               rst,
  pll_reset_ce_gen_if.master bus
);

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int PIX_W  = $clog2(CE_DIV);
  localparam int AUD_W  = $clog2(AUD_DIV);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [PIX_W-1:0]  PIX_LAST  = PIX_W'(CE_DIV - 1);
  localparam logic [AUD_W-1:0]  AUD_LAST  = AUD_W'(AUD_DIV - 1);

  if (SYNC_STAGES < 2 || HOLD_CYCLES < 1 || CE_DIV < 2 || AUD_DIV < 2 ||
      LOCK_FILTER < 1) begin : g_bad_param
    $error("pll_reset_ce_gen: parameter out of range");
  end

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RUN       = 2'd2,
    LOST      = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [PIX_W-1:0]  pix_q;
  logic [AUD_W-1:0]  aud_q;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   locked_s;
  logic                   in_hold_run;
  logic                   lock_loss;
  logic                   run_stay;

  logic core_rst_q, ready_q, ce_pix_q, ce_aud_q, lock_lost_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.pll_locked};
    end
  end

  assign locked_s    = sync_q[SYNC_STAGES-1];
  assign in_hold_run = (state_q == HOLD) || (state_q == RUN);

`ifdef LOCK_FILTER_EN
  localparam int FLT_W = (LOCK_FILTER > 1) ? $clog2(LOCK_FILTER) : 1;
  localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(LOCK_FILTER - 1);

  logic [FLT_W-1:0] flt_q;

  // flt_q counts consecutive low cycles already seen; the cycle that would
  // make LOCK_FILTER of them is the loss.
  assign lock_loss = in_hold_run && !locked_s && (flt_q == FLT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flt_q <= '0;
    end else if (!in_hold_run || locked_s || lock_loss) begin
      flt_q <= '0;
    end else begin
      flt_q <= flt_q + FLT_W'(1);
    end
  end
`else
  assign lock_loss = in_hold_run && !locked_s;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= WAIT_LOCK;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  // Loss of lock outranks soft_rst, and soft_rst outranks the HOLD exit.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      WAIT_LOCK: begin
        if (locked_s) begin
          state_d = HOLD;
          hold_d  = '0;
        end
      end
      HOLD: begin
        if (lock_loss) begin
          state_d = LOST;
        end else if (bus.soft_rst) begin
          hold_d = '0;
        end else if (hold_q == HOLD_LAST) begin
          state_d = RUN;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      RUN: begin
        if (lock_loss) begin
          state_d = LOST;
        end else if (bus.soft_rst) begin
          state_d = HOLD;
          hold_d  = '0;
        end
      end
      LOST: begin
        state_d = WAIT_LOCK;
      end
      default: begin
        state_d = WAIT_LOCK;
        hold_d  = '0;
      end
    endcase
  end

  // Dividers only advance while RUN persists across the edge, so they sit
  // at 0 on RUN entry (enables phase-aligned) and no enable fires on the
  // edge that leaves RUN.
  assign run_stay = (state_q == RUN) && (state_d == RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_q       <= '0;
      aud_q       <= '0;
      core_rst_q  <= 1'b1;
      ready_q     <= 1'b0;
      ce_pix_q    <= 1'b0;
      ce_aud_q    <= 1'b0;
      lock_lost_q <= 1'b0;
    end else begin
      pix_q       <= run_stay ? ((pix_q == PIX_LAST) ? '0 : pix_q + PIX_W'(1)) : '0;
      aud_q       <= run_stay ? ((aud_q == AUD_LAST) ? '0 : aud_q + AUD_W'(1)) : '0;
      core_rst_q  <= (state_d != RUN);
      ready_q     <= (state_d == RUN);
      ce_pix_q    <= run_stay && (pix_q == PIX_LAST);
      ce_aud_q    <= run_stay && (aud_q == AUD_LAST);
      // Entering LOST wins over a simultaneous soft_rst clear.
      if (state_d == LOST) begin
        lock_lost_q <= 1'b1;
      end else if (bus.soft_rst) begin
        lock_lost_q <= 1'b0;
      end
    end
  end

  assign bus.core_rst  = core_rst_q;
  assign bus.ready     = ready_q;
  assign bus.ce_pix    = ce_pix_q;
  assign bus.ce_aud    = ce_aud_q;
  assign bus.lock_lost = lock_lost_q;

endmodule

// File: doc/pll_reset_ce_gen.md
Name: pll_reset_ce_gen

Overview:
- Sits directly downstream of the core PLL and runs on the 49.147727 MHz system clock (PLL outclk_0).
- Synchronizes the PLL locked flag and holds the core in reset until lock has been stable for a programmable time.
- Generates single-cycle pixel and audio clock enables, so all core logic stays on one clock.
- Detects loss of lock, re-asserts core reset and records the event in a sticky flag.

Parameters:
- SYNC_STAGES, 2, flops in the pll_locked synchronizer (>=2)
- HOLD_CYCLES, 1024, clk cycles of stable lock before core_rst releases (>=1)
- CE_DIV, 8, ce_pix period in clk cycles; 49.15/8 = 6.14 MHz (>=2)
- AUD_DIV, 1024, ce_aud period in clk cycles; ~48 kHz (>=2)
- LOCK_FILTER, 8, loss-debounce length in cycles; used only with LOCK_FILTER_EN (>=1)

Ports:
- clk  in  1  system clock (PLL outclk_0)
- rst  in  1  asynchronous, active-high reset
- pll_locked  in  1  PLL locked output; asynchronous to clk
- soft_rst  in  1  synchronous core-restart request, level-sampled
- core_rst  out  1  registered, active-high reset to core logic
- ready  out  1  high while in RUN
- ce_pix  out  1  one-cycle pulse every CE_DIV cycles in RUN
- ce_aud  out  1  one-cycle pulse every AUD_DIV cycles in RUN
- lock_lost  out  1  sticky flag: lock was lost after first reaching HOLD

Behaviour:
- Reset state (rst=1, asynchronous):
  - core_rst=1, ready=0, ce_pix=0, ce_aud=0, lock_lost=0
  - all synchronizer flops, counters and the filter counter cleared
  - state=WAIT_LOCK
- All outputs are registered and derived from the next state.
- Synchronizer: locked_s is pll_locked delayed through SYNC_STAGES flops.
- State machine:
  - WAIT_LOCK: core_rst=1. If locked_s=1, go to HOLD with hold_cnt=0.
  - HOLD: core_rst=1, hold_cnt increments each cycle.
    - Loss of lock: go to LOST.
    - soft_rst=1: clear hold_cnt, stay in HOLD.
    - hold_cnt==HOLD_CYCLES-1: go to RUN.
  - RUN: core_rst=0, ready=1, divider counters run.
    - Loss of lock: go to LOST.
    - soft_rst=1: go to HOLD with hold_cnt=0; core_rst=1 at the next edge.
  - LOST: core_rst=1, lock_lost set to 1. Go to WAIT_LOCK unconditionally on the next cycle.
- Latency:
  - Count from the first clk edge that samples pll_locked=1 until the edge where core_rst falls.
  - This is SYNC_STAGES+1+HOLD_CYCLES edges; 1027 with the defaults.
- Clock enables:
  - pix_cnt and aud_cnt are held at 0 outside RUN.
  - In RUN they count 0..DIV-1 and wrap.
  - Each enable pulses in the cycle after its counter equals DIV-1, so the first ce_pix appears CE_DIV cycles after RUN entry.
  - ce_pix and ce_aud are phase-aligned at RUN entry. When AUD_DIV is a multiple of CE_DIV, every ce_aud coincides with a ce_pix.
  - Both enables are 0 in the same cycle that core_rst rises.
- Simultaneous events:
  - Loss of lock takes priority over soft_rst.
  - soft_rst clears lock_lost in any state. If loss and soft_rst occur together, lock_lost is set.
  - In WAIT_LOCK, soft_rst only clears lock_lost.
- Wrap and width:
  - hold_cnt is sized to $clog2(HOLD_CYCLES), minimum 1 bit. It never wraps, because the exit occurs at HOLD_CYCLES-1.
  - Divider counters are sized to $clog2(DIV).
- rst asserted mid-operation: immediate return to the reset state. No ce pulse is emitted during or after the assertion edge.

Optional Feature:
- Macro: LOCK_FILTER_EN
- Defined:
  - "Loss of lock" means locked_s=0 for LOCK_FILTER consecutive cycles while in HOLD or RUN.
  - The filter counter clears whenever locked_s=1. Shorter glitches are ignored: state, counters and outputs are unaffected.
  - Loss detection latency becomes SYNC_STAGES+LOCK_FILTER cycles.
- Not defined: "loss of lock" means any single cycle with locked_s=0 in HOLD or RUN. The filter counter is not built.

Test Plan:
- Bench configuration: HOLD_CYCLES=16, CE_DIV=4, AUD_DIV=8, SYNC_STAGES=2, LOCK_FILTER=3.
- Startup: rst pulse, then pll_locked=1 held → core_rst falls exactly 19 edges after the first edge sampling lock; ready=1 at the same edge; first ce_pix 4 cycles later; first ce_aud 8 cycles later, coincident with ce_pix.
- Lock loss in RUN (no macro): drop pll_locked for 1 cycle → core_rst=1 three edges later; lock_lost=1; ce stops; after lock returns the full 19-edge sequence repeats; lock_lost stays 1.
- Glitch filter (LOCK_FILTER_EN): 2-cycle low pulse on pll_locked → no change in core_rst, ready or ce cadence; 3-cycle low pulse → LOST entered and lock_lost=1.
- soft_rst in RUN: 1-cycle soft_rst → core_rst=1 next edge, ce_pix=0; core_rst falls 16 edges later; lock_lost cleared.
- Async reset mid-HOLD: assert rst at hold_cnt=10 with pll_locked still 1 → outputs reset immediately; after release, core_rst falls 19 edges later, not 6.
- Simultaneous: loss of lock and soft_rst in the same RUN cycle → state LOST, lock_lost=1.
